// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer built around one full-adder cell.
// Operands are latched on an accepted start and processed LSB first,
// one bit per clock. Subtraction feeds ~b with carry-in 1.
// Optional build macro: ADDSUB_SAT_EN saturates the result on signed overflow.
module serial_addsub_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  // Holds the sum bits already produced; the current bit completes the word.
  logic [WIDTH-2:0] r_acc;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_ovf;

  // Single full-adder cell on the current LSBs and the running carry.
  always_comb begin
    w_sum  = r_opA[0] ^ r_opB[0] ^ r_cy;
    w_cout = (r_opA[0] & r_opB[0]) | (r_cy & (r_opA[0] ^ r_opB[0]));
    w_word = {w_sum, r_acc};
    w_last = (r_cnt == CW'(WIDTH - 1));
    w_ovf  = r_cy ^ w_cout;
  end

  // Sequencer: accept, shift one bit per cycle, publish results on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opA    <= '0;
      r_opB    <= '0;
      r_cy     <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_opA   <= a;
            r_opB   <= op ? ~b : b;
            r_cy    <= op;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_word[WIDTH-1:1];
          r_opA <= r_opA >> 1;
          r_opB <= r_opB >> 1;
          r_cy  <= w_cout;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
`ifdef ADDSUB_SAT_EN
            // MSB sum of 1 on overflow means two positives wrapped negative.
            if (w_ovf)
              r_result <= w_sum ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
            else
              r_result <= w_word;
`else
            r_result <= w_word;
`endif
            r_carry <= w_cout;
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign carryOut = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Self-checking bench for serial_addsub_seq (WIDTH=5): directed cases plus
// randomized operations compared against an integer-arithmetic reference.
module tb_serial_addsub_seq;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carryOut, overflow;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] last_res;
  logic         last_cy, last_ov;

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carryOut(carryOut),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    int ua, ub, sa, sb, ts, maxp, minn;
    logic [W-1:0] r;
    logic cy, ov;
    ua = int'(ma); ub = int'(mb);
    sa = int'($signed(ma)); sb = int'($signed(mb));
    maxp = (1 << (W-1)) - 1;
    minn = -(1 << (W-1));
    ts = mop ? sa - sb : sa + sb;
    ov = (ts > maxp) || (ts < minn);
    if (mop) begin
      cy = (ua >= ub);
      r  = W'(ua - ub);
    end else begin
      cy = ((ua + ub) >= (1 << W));
      r  = W'(ua + ub);
    end
`ifdef ADDSUB_SAT_EN
    if (ov) r = (ts > 0) ? W'(maxp) : W'(minn);
`endif
    return {r, cy, ov};
  endfunction

  // Drive a request at #1 after an edge; it is accepted at the next edge.
  task automatic launch(input logic lop, input logic [W-1:0] la, input logic [W-1:0] lb);
    start = 1'b1; op = lop; a = la; b = lb;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Wait for done, checking latency, busy span and results. Optionally pulse
  // start mid-run with unrelated operands, which must be ignored.
  task automatic finish_op(input string tag, input logic lop, input logic [W-1:0] la,
                           input logic [W-1:0] lb, input bit mid);
    int cyc = 0;
    int busy_cyc = 1;
    logic [W+1:0] exp;
    exp = model(lop, la, lb);
    while (cyc < 3*W) begin
      if (mid && cyc == 1) begin
        start = 1'b1; op = ~lop; a = ~la; b = la;
      end else if (mid && cyc == 2) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (busy) busy_cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(W));
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(exp[W+1:2]));
    check({tag, "_carry"}, 32'(carryOut), 32'(exp[1]));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp[0]));
    last_res = exp[W+1:2]; last_cy = exp[1]; last_ov = exp[0];
  endtask

  // One idle cycle after done: pulse must drop and outputs must hold.
  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'({result, carryOut, overflow}), 32'({last_res, last_cy, last_ov}));
  endtask

  task automatic do_op(input string tag, input logic lop, input logic [W-1:0] la, input logic [W-1:0] lb);
    launch(lop, la, lb);
    finish_op(tag, lop, la, lb, 1'b0);
    idle_check(tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rop;
    #2;
    check("reset_outputs", 32'({busy, done, result, carryOut, overflow}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // T1..T4 directed
    do_op("t1_add", 1'b0, 5'b00101, 5'b00011);
    do_op("t2_sub", 1'b1, 5'b00101, 5'b00011);
    do_op("t2_sub_neg", 1'b1, 5'b00000, 5'b00001);
    do_op("zero_sub", 1'b1, 5'b00000, 5'b00000);
    do_op("t3_pos_ovf", 1'b0, 5'b01111, 5'b00001);
    do_op("t4_neg_ovf", 1'b1, 5'b10000, 5'b00001);
    do_op("max_add", 1'b0, 5'b11111, 5'b11111);

    // T5: mid-run start ignored, then back-to-back via start held in DONE
    launch(1'b0, 5'b00101, 5'b00011);
    finish_op("t5_mid_start", 1'b0, 5'b00101, 5'b00011, 1'b1);
    launch(1'b1, 5'b01010, 5'b00111);
    finish_op("t5_b2b", 1'b1, 5'b01010, 5'b00111, 1'b0);
    idle_check("t5_b2b");

    // Randomized operations, some chained back-to-back
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 1'($urandom);
      launch(rop, ra, rb);
      finish_op("rand", rop, ra, rb, 1'b0);
      if ($urandom_range(0, 1) == 0) idle_check("rand");
    end
    idle_check("rand_tail");

    // T6: reset at cnt=2 aborts immediately
    launch(1'b0, 5'b00111, 5'b00110);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_reset_abort", 32'({busy, done, result, carryOut, overflow}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_done_in_reset", 32'({busy, done}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("t6_fresh_add", 1'b0, 5'b00001, 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
